// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide sharing a single double-width accumulator.
//
// state  | meaning
// IDLE   | waiting for start; busy low
// PREP   | signedness, absolute values, special-case detection
// CALC   | size iterations of shift-add / shift-subtract
// FINISH | sign correction, output slice select, done pulse
module mul_div_unit #(
    parameter int size = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [size-1:0] operand_a,
    input  logic [size-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] result
);

    localparam int CW = $clog2(size);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PREP   = 2'd1;
    localparam logic [1:0] CALC   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;
    localparam logic [CW-1:0]   LAST     = CW'(size - 1);
    localparam logic [size-1:0] ONES     = '1;
    localparam logic [size-1:0] MOST_NEG = {1'b1, {(size-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [size-1:0]   a_q, a_d;
    logic [size-1:0]   b_q, b_d;
    logic [size-1:0]   result_q, result_d;
    logic [2*size-1:0] acc_q, acc_d;
    logic [CW-1:0]     counter_q, counter_d;
    logic              neg_q, neg_d;
    logic              done_q, done_d;

    logic              signed_a, signed_b, sign_a, sign_b;
    logic              is_div, is_rem, div_zero, overflow;
    logic [size-1:0]   abs_a, abs_b;
    logic [size:0]     mul_sum, div_shift, div_diff;
    logic [2*size-1:0] mul_next, div_next, prod_fix;
    logic [size-1:0]   quo_fix, rem_fix, final_res;

    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    assign signed_a = (op_q == 3'b001) | (op_q == 3'b010) | (op_q == 3'b100) | (op_q == 3'b110);
    assign signed_b = (op_q == 3'b001) | (op_q == 3'b100) | (op_q == 3'b110);
    assign sign_a   = signed_a & a_q[size-1];
    assign sign_b   = signed_b & b_q[size-1];
    assign abs_a    = sign_a ? -a_q : a_q;
    assign abs_b    = sign_b ? -b_q : b_q;
    assign div_zero = is_div & (b_q == '0);
    assign overflow = is_div & ~op_q[0] & (a_q == MOST_NEG) & (b_q == ONES);

    // Multiply: accumulator = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*size-1:size]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[size-1:1]};

    // Divide: accumulator = {partial remainder, dividend bits / quotient bits}
    assign div_shift = {acc_q[2*size-1:size], acc_q[size-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_next  = div_diff[size] ? {div_shift[size-1:0], acc_q[size-2:0], 1'b0}
                                      : {div_diff[size-1:0],  acc_q[size-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[size-1:0] : acc_q[size-1:0];
    assign rem_fix  = neg_q ? -acc_q[2*size-1:size] : acc_q[2*size-1:size];

    always_comb begin
        final_res = rem_fix;
        case (op_q)
            3'b000:                 final_res = prod_fix[size-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*size-1:size];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        counter_d = counter_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PREP;
                    op_d    = funct3;
                    a_d     = operand_a;
                    b_d     = operand_b;
                end
            end
            PREP: begin
                counter_d = '0;
                // Special results are preloaded so FINISH picks them with the normal slice
                if (div_zero) begin
                    acc_d   = {a_q, ONES};
                    neg_d   = 1'b0;
                    state_d = FINISH;
                end else if (overflow) begin
                    acc_d   = {{size{1'b0}}, MOST_NEG};
                    neg_d   = 1'b0;
                    state_d = FINISH;
                end else begin
                    acc_d   = {{size{1'b0}}, abs_a};
                    b_d     = abs_b;
                    neg_d   = is_rem ? sign_a : (sign_a ^ sign_b);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d     = is_div ? div_next : mul_next;
                counter_d = counter_q + CW'(1);
                if (counter_q == LAST) state_d = FINISH;
            end
            FINISH: begin
                result_d = final_res;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            counter_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            counter_q <= counter_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model with a per-cycle compare of
// busy/done/result, directed literal cases, and a randomized issue/reset phase.
module tb_mul_div_unit;

    localparam int SIZE = 32;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.size(SIZE)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = ua / ub; return q[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = ua % ub; return q[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Reference: an accepted op completes a fixed number of edges later
    bit          m_started = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_done    = 1'b0;
    logic [31:0] m_result  = '0;
    logic [31:0] m_pending = '0;
    int          m_left    = 0;

    always @(posedge CLK) begin
        m_started = 1'b1;
        if (RESET) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_result = '0;
            m_left   = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_result = m_pending;
                end
            end else if (start) begin
                m_busy    = 1'b1;
                m_pending = ref_result(funct3, operand_a, operand_b);
                m_left    = is_special(funct3, operand_a, operand_b) ? 2 : SIZE + 2;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_started) begin
            chk("cyc_busy",   32'(busy), 32'(m_busy));
            chk("cyc_done",   32'(done), 32'(m_done));
            chk("cyc_result", result,    m_result);
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        funct3    = op;
        operand_a = a;
        operand_b = b;
        @(negedge CLK);
        start     = 1'b0;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        chk({name, "_model"}, ref_result(op, a, b), exp);
        issue(op, a, b);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({name, "_result"}, result, exp);
        chk({name, "_latency"}, 32'(n), 32'(lat));
    endtask

    initial begin
        int n;
        int seen;
        RESET     = 1'b1;
        start     = 1'b0;
        funct3    = 3'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge CLK);
        chk("reset_busy",   32'(busy), 32'd0);
        chk("reset_done",   32'(done), 32'd0);
        chk("reset_result", result,    32'd0);
        RESET = 1'b0;

        run_lit("mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_lit("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_lit("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_lit("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_lit("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_lit("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_lit("divu",     3'd5, 32'd100,       32'd7,         32'd14,        34);
        run_lit("remu",     3'd7, 32'd100,       32'd7,         32'd2,         34);
        run_lit("divu_z",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_lit("remu_z",   3'd7, 32'd5,         32'd0,         32'd5,         2);
        run_lit("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_lit("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2);

        // start while busy is ignored; start in the done cycle is accepted
        issue(3'd5, 32'd100, 32'd7);
        repeat (4) @(negedge CLK);
        start     = 1'b1;
        funct3    = 3'd0;
        operand_a = 32'd3;
        operand_b = 32'd3;
        @(negedge CLK);
        start     = 1'b0;
        operand_a = 32'd9999;
        operand_b = 32'd1234;
        wait_done(n);
        chk("b2b_ignored_result",  result,       32'd14);
        chk("b2b_ignored_latency", 32'(n + 5),   32'd34);
        run_lit("b2b_mul", 3'd0, 32'd3, 32'd3, 32'd9, 34);
        run_lit("b2b_rem_z", 3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678, 2);

        // reset aborts an in-flight divide without a done pulse
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_busy",   32'(busy), 32'd0);
        chk("abort_done",   32'(done), 32'd0);
        chk("abort_result", result,    32'd0);
        RESET = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge CLK);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // random issue pattern, including starts while busy and rare resets
        repeat (6000) begin
            RESET     = ($urandom_range(0, 999) == 0);
            start     = ($urandom_range(0, 3) == 0);
            funct3    = 3'($urandom);
            operand_a = rand_operand();
            operand_b = rand_operand();
            @(negedge CLK);
        end
        RESET = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Sits directly downstream of the ALU operand-select 2-input muxes and consumes their selected outputs as operand_a and operand_b.
- Takes one operation per start pulse and returns a registered result with a done pulse.
- The control unit stalls the pipeline while busy is high.

Parameters:
size, 32, operand/result width in bits (must be >= 2)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only while busy=0
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  size  rs1 value (mux output); multiplicand / dividend
operand_b  input  size  rs2 value (mux output); multiplier / divisor
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: result valid
result  output  size  result register; holds value until next accepted operation completes

Behaviour:
- Reset: at a rising CLK edge with RESET=1, state=IDLE and busy=0, done=0, result=0, counter=0. RESET overrides start and aborts any in-flight operation; no done is produced for it.
- Register states:
  - IDLE: busy=0.
  - PREP
  - CALC
  - FINISH
- busy = (state != IDLE), combinational from the state register.
- IDLE -> PREP on an edge with start=1.
  - Latch funct3, operand_a and operand_b.
  - Later changes on these inputs are ignored.
- PREP (1 cycle):
  - Compute operand signedness per op: MULH/DIV/REM signed both; MULHSU a signed, b unsigned; MUL and the unsigned ops treat both as unsigned.
  - Take absolute values and record the result sign.
  - Detect special cases:
    - divide-by-zero: op is div/rem and b=0.
    - signed overflow: DIV/REM with a = most-negative and b = all ones.
  - Special case -> FINISH. Otherwise -> CALC with counter=0.
- CALC:
  - Exactly size cycles, one bit per cycle.
  - Multiply: shift-add into a 2*size-bit product.
  - Divide: restoring shift-subtract producing size-bit quotient and remainder.
  - Leaves to FINISH when counter = size-1.
- FINISH (1 cycle):
  - Apply sign correction and select the output slice.
  - MUL: low size bits.
  - MULH/MULHSU/MULHU: high size bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient sign = sign_a XOR sign_b. Remainder sign = sign of dividend.
  - Write result, set done=1 for the next cycle, -> IDLE.
- Special-case results:
  - Divide-by-zero: DIV/DIVU -> all ones; REM/REMU -> operand_a.
  - Overflow: DIV -> most-negative (1 followed by zeros); REM -> 0.
- Latency, counted from the edge that accepts start:
  - Normal ops: done is high in the cycle following edge size+2 (34 cycles at size=32).
  - Special cases: done follows edge 2.
- done is high for exactly one cycle, with state=IDLE. A start in that same cycle is accepted (back-to-back issue; no bubble).
- start while busy=1 is ignored and does not disturb the in-flight operation.
- result changes only at the FINISH edge or on reset; it is stable between done pulses.

Test Plan:
- RESET=1 for 2 cycles, then start MUL a=7, b=0xFFFFFFFD -> busy=1 the next cycle; done after exactly 34 cycles; result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with done 2 cycles after start; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start DIVU 100/7, then pulse start with MUL 3x3 at cycle 5 and change operands -> ignored; result=14 at cycle 34. Issue a new start in the done cycle -> accepted; its done follows 34 cycles later.
- Start DIV, assert RESET at cycle 10 -> next cycle busy=0, done=0, result=0; no done pulse appears afterwards.
